// File: rtl/mb_rx_data_buffer_pkg.sv
// Shared mainband definitions: datapath widths, receive buffer defaults and
// the occupancy state encoding used by the receive data buffer.
package mb_rx_data_buffer_pkg;

  localparam int MB_DATA_WIDTH        = 512;
  localparam int MB_LANE_WIDTH        = 32;
  localparam int MB_RXBUF_DEPTH       = 4;
  localparam int MB_RXBUF_AFULL_LEVEL = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_FULL   = 2'd2
  } mb_occ_state_e;

endpackage

// File: rtl/mb_rx_buf_mem.sv
// Word storage for the receive buffer: one synchronous write port and one
// asynchronous read port. The array itself is intentionally not reset.
module mb_rx_buf_mem
  import mb_rx_data_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = MB_DATA_WIDTH,
  parameter int DEPTH      = MB_RXBUF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/mb_rx_data_buffer.sv
// Receive-side mainband buffer: first-word-fall-through FIFO between the
// lane-to-byte demapper and the adapter consumer, with sticky overflow flag.
//
// state      | meaning
// OCC_EMPTY  | no words held, o_valid low, o_data 0
// OCC_ACTIVE | 1 .. DEPTH-1 words held
// OCC_FULL   | DEPTH words held, new words dropped unless popping
module mb_rx_data_buffer
  import mb_rx_data_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = MB_DATA_WIDTH,
  parameter int DEPTH       = MB_RXBUF_DEPTH,
  parameter int AFULL_LEVEL = MB_RXBUF_AFULL_LEVEL
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_data_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  mb_occ_state_e         state, state_next;
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]         count, count_next;
  logic                  push, pop, drop, full, head_is_new;
  logic [DATA_WIDTH-1:0] head_rdata, data_q, data_next;
  logic                  afull_q, ovf_q;

  assign full    = (state == OCC_FULL);
  assign o_valid = (state != OCC_EMPTY);

  assign pop  = i_enable & o_valid & i_ready;
  assign push = i_enable & i_data_valid & (~full | pop);
  assign drop = i_enable & i_data_valid & full & ~pop;

  assign count_next  = count + CW'(push) - CW'(pop);
  assign rd_ptr_next = rd_ptr + AW'(pop);

  // When the buffer is (or is about to be) empty, the word written this
  // cycle becomes the head; take it straight from the input for o_data.
  assign head_is_new = push & (count == CW'(pop));

  mb_rx_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr),
    .i_wdata (i_data),
    .i_raddr (rd_ptr_next),
    .o_rdata (head_rdata)
  );

  always_comb begin
    data_next = '0;
    if (count_next != '0) data_next = head_is_new ? i_data : head_rdata;
  end

  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY:  if (push) state_next = OCC_ACTIVE;
        OCC_ACTIVE: begin
          if (count_next == DEPTH_C)  state_next = OCC_FULL;
          else if (count_next == '0)  state_next = OCC_EMPTY;
        end
        OCC_FULL:   if (pop && !push) state_next = OCC_ACTIVE;
        default:    state_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= OCC_EMPTY;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!i_enable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      data_q  <= data_next;
      afull_q <= (count_next >= AFULL_C);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign o_data        = data_q;
  assign o_count       = count;
  assign o_almost_full = afull_q;
  assign o_overflow    = ovf_q;

endmodule
